tx_link_ctrl: RTL and testbench
===============================

# tx_link_ctrl

Parametrised JESD204 transmit link controller, successor to the single-link TX control unit. It sequences IDLE → LMFC alignment → CGS → ILA → DATA for up to LANES lanes and combines several SYNC inputs. ILA length is a programmable number of multiframes, and every transition lands on an LMFC boundary. In DATA, a short SYNC low is classified as an error report and a long one as a resync request, with saturating counters for both. It sits between the LMFC generator and the per-lane ILA/character generators.

## Interface
Parameters:
- LANES, 4, number of lanes (1..16)
- SYNC_NUM, 1, number of SYNC inputs, ANDed into one link SYNC
- RESYNC_FRAMES, 5, consecutive frames of SYNC low that constitute a resync request (≥2)

Ports:
- CLK  in  1  link clock
- RST_n  in  1  reset; synchronous, active-low
- LANE_EN  in  LANES  per-lane enable
- SUBCLASSV  in  3  0 = subclass 0 (skip LMFC alignment), otherwise subclass 1/2
- SYNC  in  SYNC_NUM  active-high "receiver synchronised"; link SYNC = &SYNC
- LMFC_SYNCED  in  1  LMFC generator aligned to SYSREF
- LMFC_EDGE  in  1  one-cycle pulse at each LMFC boundary
- FRAME_TICK  in  1  one-cycle pulse per frame
- ILA_DELAY  in  8  multiframes SYNC must stay high in CGS before ILA
- ILA_MF_NUM  in  8  ILA length in multiframes; 0 means 4
- CNT_CLR  in  1  clears both status counters
- LMFC_EN  out  1  LMFC generator enable
- ILA_EN  out  LANES  per-lane ILA generator enable
- CHAR_EN  out  LANES  per-lane user-data enable
- ILA_START  out  1  one-cycle pulse, first cycle of ILA
- LINK_UP  out  1  state is DATA
- STATE  out  5  one-hot state, for debug
- SYNC_ERR_CNT  out  8  count of SYNC error reports, saturating at 255
- RESYNC_CNT  out  8  count of resync/abort events, saturating at 255

## Operation
- Any-lane condition: any_lane = |LANE_EN. If any_lane = 0, the next state is IDLE from every state.
- IDLE → CGS if SUBCLASSV = 0, else → LMFC_ALIGN. Each transition requires any_lane = 1.
- LMFC_ALIGN → CGS when LMFC_SYNCED = 1.
- CGS:
  - mf_cnt is cleared whenever SYNC = 0.
  - While SYNC = 1, each LMFC_EDGE with mf_cnt < ILA_DELAY increments mf_cnt.
  - → ILA on a cycle with LMFC_EDGE && SYNC && mf_cnt == ILA_DELAY.
  - If ILA_DELAY = 0, ILA therefore starts on the first LMFC_EDGE with SYNC high.
- ILA:
  - ila_cnt counts LMFC_EDGE pulses.
  - → DATA on the edge where ila_cnt == N−1, where N = ILA_MF_NUM, or 4 if ILA_MF_NUM = 0.
  - SYNC = 0 in any ILA cycle → IDLE, and RESYNC_CNT increments.
- DATA, with low_cnt counting FRAME_TICK pulses while SYNC = 0:
  - low_cnt reaching RESYNC_FRAMES → IDLE, and RESYNC_CNT increments.
  - SYNC rising with 0 < low_cnt < RESYNC_FRAMES → stay in DATA, SYNC_ERR_CNT increments, low_cnt clears.
  - A low pulse seeing no FRAME_TICK (low_cnt = 0) still counts as an error report.
  - low_cnt clears on any entry to DATA.
- Counters:
  - CNT_CLR has priority over a simultaneous increment.
  - Both counters saturate at 255 and never wrap.
  - Counters are unaffected by state; only reset and CNT_CLR clear them.
- Outputs, decoded combinationally from the registered state:
  - LMFC_EN = state ∉ {IDLE}.
  - ILA_EN[i] = LANE_EN[i] && state ∈ {ILA, DATA}.
  - CHAR_EN[i] = LANE_EN[i] && state == DATA.
  - LINK_UP = state == DATA.

## Timing
- Reset values: state IDLE; mf_cnt, ila_cnt, low_cnt = 0; LMFC_EN, ILA_EN, CHAR_EN, ILA_START, LINK_UP = 0; STATE = 5'b00001; both counters = 0.
- State changes one cycle after the qualifying input cycle. Outputs follow the state in the same cycle.
- ILA_START is registered: high for exactly the first cycle in ILA.
- LANE_EN gating of ILA_EN/CHAR_EN is immediate (zero latency), without waiting for a state change.
- Simultaneous events:
  - SYNC fall and LMFC_EDGE in the same CGS cycle: no transition, mf_cnt → 0.
  - SYNC fall and final ILA LMFC_EDGE in the same cycle: abort wins → IDLE.
  - FRAME_TICK on the cycle SYNC rises: the tick is not counted.
- Reset asserted mid-ILA or mid-DATA: next cycle is IDLE with all outputs low. No counter increment.

## Structure
- Package tx_link_pkg:
  - state enum (5-bit one-hot: IDLE, LMFC_ALIGN, CGS, ILA, DATA);
  - ILA_MF_DEFAULT = 4;
  - counter width constant CNT_W = 8.
- Sub-module tx_sync_mon:
  - SYNC AND-combine;
  - low_cnt;
  - error/resync classification, outputs err_pulse and resync_pulse;
  - the two saturating counters.
- The top level holds the state machine, mf_cnt, ila_cnt and output decode.

## Test plan
- Subclass 1, LANES=4, LANE_EN=4'b0101, ILA_DELAY=2, ILA_MF_NUM=0, SYNC high after LMFC_SYNCED:
  - ILA_START exactly one cycle after the 3rd LMFC_EDGE with SYNC high;
  - ILA_EN=4'b0101;
  - DATA after 4 edges, then CHAR_EN=4'b0101.
- Subclass 0, ILA_DELAY=0, ILA_MF_NUM=1: no LMFC_ALIGN state; ILA starts on the first edge and DATA follows on the next.
- In DATA, RESYNC_FRAMES=5, SYNC low for 3 FRAME_TICKs then high: stays DATA, SYNC_ERR_CNT=1. Low for 5 ticks: IDLE, RESYNC_CNT=1, LINK_UP=0.
- SYNC=2'b10 (SYNC_NUM=2) during ILA: abort to IDLE; RESYNC_CNT increments. 256 such aborts: RESYNC_CNT holds at 255. CNT_CLR coincident with an abort: counter reads 0.
- LANE_EN→0 in DATA: CHAR_EN=0 the same cycle, state IDLE the next cycle.
- RST_n low for one cycle mid-ILA: all outputs 0 next cycle, counters 0, sequence restarts from IDLE.

Source files
------------

// File: rtl/tx_link_pkg.sv
// tx_link_pkg: shared types and constants for the JESD204 TX link controller.
//   state_t        one-hot link state (IDLE, LMFC_ALIGN, CGS, ILA, DATA)
//   ILA_MF_DEFAULT ILA length used when ILA_MF_NUM is 0
//   CNT_W          width of the status counters
//   sat_inc        saturating increment for status counters
package tx_link_pkg;

  localparam int unsigned CNT_W          = 8;
  localparam int unsigned ILA_MF_DEFAULT = 4;

  typedef enum logic [4:0] {
    ST_IDLE       = 5'b00001,
    ST_LMFC_ALIGN = 5'b00010,
    ST_CGS        = 5'b00100,
    ST_ILA        = 5'b01000,
    ST_DATA       = 5'b10000
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tx_sync_mon.sv
// tx_sync_mon: link SYNC monitor.
//   CLK, RST_n       clock, synchronous active-low reset
//   i_sync           raw SYNC inputs, ANDed into the link SYNC
//   i_frame_tick     one pulse per frame
//   i_in_ila         controller is in ILA
//   i_in_data        controller is in DATA
//   i_cnt_clr        clears both counters (priority over increments)
//   o_link_sync      combined link SYNC
//   o_err_pulse      short SYNC low ended in DATA (error report)
//   o_resync_pulse   resync request in DATA or SYNC loss during ILA
//   o_sync_err_cnt   saturating count of error reports
//   o_resync_cnt     saturating count of resync/abort events
module tx_sync_mon
  import tx_link_pkg::*;
#(
  parameter int unsigned SYNC_NUM      = 1,
  parameter int unsigned RESYNC_FRAMES = 5
) (
  input  logic                CLK,
  input  logic                RST_n,
  input  logic [SYNC_NUM-1:0] i_sync,
  input  logic                i_frame_tick,
  input  logic                i_in_ila,
  input  logic                i_in_data,
  input  logic                i_cnt_clr,
  output logic                o_link_sync,
  output logic                o_err_pulse,
  output logic                o_resync_pulse,
  output logic [CNT_W-1:0]    o_sync_err_cnt,
  output logic [CNT_W-1:0]    o_resync_cnt
);

  localparam int unsigned      LOW_W    = $clog2(RESYNC_FRAMES + 1);
  localparam logic [LOW_W-1:0] LOW_LAST = LOW_W'(RESYNC_FRAMES - 1);

  logic             w_link_sync;
  logic             w_low_expire;
  logic [LOW_W-1:0] r_low_cnt;
  logic             r_sync_d;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_resync_cnt;

  assign w_link_sync = &i_sync;

  // The frame that would bring low_cnt to RESYNC_FRAMES is the resync request
  // itself, so the controller leaves DATA one cycle after that tick.
  assign w_low_expire = i_in_data && !w_link_sync && i_frame_tick && (r_low_cnt == LOW_LAST);

  // Any rising SYNC in DATA ends a short low pulse, including one that saw no
  // frame tick; a long pulse has already taken the link out of DATA.
  assign o_err_pulse    = i_in_data && w_link_sync && !r_sync_d;
  assign o_resync_pulse = w_low_expire || (i_in_ila && !w_link_sync);
  assign o_link_sync    = w_link_sync;
  assign o_sync_err_cnt = r_err_cnt;
  assign o_resync_cnt   = r_resync_cnt;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_low_cnt    <= '0;
      r_sync_d     <= 1'b1;
      r_err_cnt    <= '0;
      r_resync_cnt <= '0;
    end else begin
      r_sync_d <= w_link_sync;

      if (!i_in_data || w_link_sync || w_low_expire)
        r_low_cnt <= '0;
      else if (i_frame_tick)
        r_low_cnt <= r_low_cnt + 1'b1;

      if (i_cnt_clr)
        r_err_cnt <= '0;
      else if (o_err_pulse)
        r_err_cnt <= sat_inc(r_err_cnt);

      if (i_cnt_clr)
        r_resync_cnt <= '0;
      else if (o_resync_pulse)
        r_resync_cnt <= sat_inc(r_resync_cnt);
    end
  end

endmodule

// File: rtl/tx_link_ctrl.sv
// tx_link_ctrl: JESD204 transmit link controller.
// Sequences IDLE -> LMFC_ALIGN -> CGS -> ILA -> DATA on LMFC boundaries.
//   CLK, RST_n     link clock, synchronous active-low reset
//   LANE_EN        per-lane enable; all-zero forces IDLE
//   SUBCLASSV      0 skips LMFC alignment
//   SYNC           receiver SYNC inputs (ANDed)
//   LMFC_SYNCED    LMFC generator aligned
//   LMFC_EDGE      LMFC boundary pulse
//   FRAME_TICK     frame pulse
//   ILA_DELAY      multiframes of SYNC high in CGS before ILA
//   ILA_MF_NUM     ILA length in multiframes (0 = 4)
//   CNT_CLR        clears status counters
//   LMFC_EN, ILA_EN, CHAR_EN, LINK_UP  decoded from state (lane-gated)
//   ILA_START      registered pulse on first ILA cycle
//   STATE          one-hot state
//   SYNC_ERR_CNT, RESYNC_CNT  saturating status counters
module tx_link_ctrl
  import tx_link_pkg::*;
#(
  parameter int unsigned LANES         = 4,
  parameter int unsigned SYNC_NUM      = 1,
  parameter int unsigned RESYNC_FRAMES = 5
) (
  input  logic                CLK,
  input  logic                RST_n,
  input  logic [LANES-1:0]    LANE_EN,
  input  logic [2:0]          SUBCLASSV,
  input  logic [SYNC_NUM-1:0] SYNC,
  input  logic                LMFC_SYNCED,
  input  logic                LMFC_EDGE,
  input  logic                FRAME_TICK,
  input  logic [7:0]          ILA_DELAY,
  input  logic [7:0]          ILA_MF_NUM,
  input  logic                CNT_CLR,
  output logic                LMFC_EN,
  output logic [LANES-1:0]    ILA_EN,
  output logic [LANES-1:0]    CHAR_EN,
  output logic                ILA_START,
  output logic                LINK_UP,
  output logic [4:0]          STATE,
  output logic [CNT_W-1:0]    SYNC_ERR_CNT,
  output logic [CNT_W-1:0]    RESYNC_CNT
);

  state_t     r_state;
  logic [7:0] r_mf_cnt;
  logic [7:0] r_ila_cnt;
  logic       r_ila_start;

  logic       w_any_lane;
  logic       w_link_sync;
  logic       w_err_pulse;
  logic       w_resync_pulse;
  logic [7:0] w_ila_last;

  assign w_any_lane = |LANE_EN;
  assign w_ila_last = (ILA_MF_NUM == 8'd0) ? 8'(ILA_MF_DEFAULT - 1) : ILA_MF_NUM - 8'd1;

  tx_sync_mon #(
    .SYNC_NUM      (SYNC_NUM),
    .RESYNC_FRAMES (RESYNC_FRAMES)
  ) u_sync_mon (
    .CLK            (CLK),
    .RST_n          (RST_n),
    .i_sync         (SYNC),
    .i_frame_tick   (FRAME_TICK),
    .i_in_ila       (r_state == ST_ILA),
    .i_in_data      (r_state == ST_DATA),
    .i_cnt_clr      (CNT_CLR),
    .o_link_sync    (w_link_sync),
    .o_err_pulse    (w_err_pulse),
    .o_resync_pulse (w_resync_pulse),
    .o_sync_err_cnt (SYNC_ERR_CNT),
    .o_resync_cnt   (RESYNC_CNT)
  );

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_state     <= ST_IDLE;
      r_mf_cnt    <= '0;
      r_ila_cnt   <= '0;
      r_ila_start <= 1'b0;
    end else begin
      r_ila_start <= 1'b0;
      if (!w_any_lane) begin
        r_state  <= ST_IDLE;
        r_mf_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_mf_cnt <= '0;
            r_state  <= (SUBCLASSV == 3'd0) ? ST_CGS : ST_LMFC_ALIGN;
          end
          ST_LMFC_ALIGN: begin
            r_mf_cnt <= '0;
            if (LMFC_SYNCED)
              r_state <= ST_CGS;
          end
          ST_CGS: begin
            // SYNC low wins over a coincident LMFC edge: count restarts.
            if (!w_link_sync)
              r_mf_cnt <= '0;
            else if (LMFC_EDGE) begin
              if (r_mf_cnt == ILA_DELAY) begin
                r_state     <= ST_ILA;
                r_ila_start <= 1'b1;
                r_ila_cnt   <= '0;
              end else
                r_mf_cnt <= r_mf_cnt + 1'b1;
            end
          end
          ST_ILA: begin
            // SYNC loss aborts even on the final ILA edge.
            if (w_resync_pulse)
              r_state <= ST_IDLE;
            else if (LMFC_EDGE) begin
              if (r_ila_cnt == w_ila_last)
                r_state <= ST_DATA;
              else
                r_ila_cnt <= r_ila_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            // Error reports are counted by the monitor; the link stays up.
            if (w_resync_pulse)
              r_state <= ST_IDLE;
            else if (w_err_pulse)
              r_state <= ST_DATA;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign LMFC_EN   = (r_state != ST_IDLE);
  assign ILA_EN    = LANE_EN & {LANES{(r_state == ST_ILA) || (r_state == ST_DATA)}};
  assign CHAR_EN   = LANE_EN & {LANES{r_state == ST_DATA}};
  assign LINK_UP   = (r_state == ST_DATA);
  assign ILA_START = r_ila_start;
  assign STATE     = r_state;

endmodule

// File: tb/tb_tx_link_ctrl.sv
module tb_tx_link_ctrl;
  localparam int unsigned LANES = 4;
  localparam int unsigned SNUM  = 2;
  localparam int unsigned RF    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [LANES-1:0] lane_en;
  logic [2:0]       subclassv;
  logic [SNUM-1:0]  sync;
  logic             lmfc_synced, lmfc_edge, frame_tick, cnt_clr;
  logic [7:0]       ila_delay, ila_mf;
  logic             lmfc_en, ila_start, link_up;
  logic [LANES-1:0] ila_en, char_en;
  logic [4:0]       state;
  logic [7:0]       err_cnt, res_cnt;

  always #5 clk = ~clk;

  tx_link_ctrl #(.LANES(LANES), .SYNC_NUM(SNUM), .RESYNC_FRAMES(RF)) dut (
    .CLK(clk), .RST_n(rst_n), .LANE_EN(lane_en), .SUBCLASSV(subclassv), .SYNC(sync),
    .LMFC_SYNCED(lmfc_synced), .LMFC_EDGE(lmfc_edge), .FRAME_TICK(frame_tick),
    .ILA_DELAY(ila_delay), .ILA_MF_NUM(ila_mf), .CNT_CLR(cnt_clr),
    .LMFC_EN(lmfc_en), .ILA_EN(ila_en), .CHAR_EN(char_en), .ILA_START(ila_start),
    .LINK_UP(link_up), .STATE(state), .SYNC_ERR_CNT(err_cnt), .RESYNC_CNT(res_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0..4 = IDLE, LMFC_ALIGN, CGS, ILA, DATA.
  int m_ph, m_good, m_ila, m_low, m_err, m_res;
  bit m_first, m_prev_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the currently driven inputs: check outputs against the
  // model mid-cycle, advance the model by the rules, then cross the edge.
  task automatic step(input bit do_chk);
    bit s, lane, inc_e, inc_r, n_first;
    int n_ph, n_good, n_ila, n_low, ila_len;
    #2;
    if (do_chk) begin
      chk("STATE", 32'(state), 32'(1) << m_ph);
      chk("ILA_START", 32'(ila_start), 32'(m_first));
      chk("LMFC_EN", 32'(lmfc_en), 32'(m_ph != 0));
      chk("ILA_EN", 32'(ila_en), (m_ph >= 3) ? 32'(lane_en) : 32'd0);
      chk("CHAR_EN", 32'(char_en), (m_ph == 4) ? 32'(lane_en) : 32'd0);
      chk("LINK_UP", 32'(link_up), 32'(m_ph == 4));
      chk("SYNC_ERR_CNT", 32'(err_cnt), 32'(m_err));
      chk("RESYNC_CNT", 32'(res_cnt), 32'(m_res));
    end
    s = &sync; lane = |lane_en;
    n_ph = m_ph; n_good = m_good; n_ila = m_ila; n_low = m_low;
    n_first = 0; inc_e = 0; inc_r = 0;
    ila_len = (ila_mf == 0) ? 4 : int'(ila_mf);
    case (m_ph)
      0: begin n_good = 0; n_ph = (subclassv == 0) ? 2 : 1; end
      1: begin n_good = 0; if (lmfc_synced) n_ph = 2; end
      2: if (!s) n_good = 0;
         else if (lmfc_edge) begin
           if (m_good == int'(ila_delay)) begin n_ph = 3; n_first = 1; n_ila = 0; end
           else n_good = m_good + 1;
         end
      3: if (!s) begin inc_r = 1; n_ph = 0; end
         else if (lmfc_edge) begin
           if (m_ila + 1 == ila_len) n_ph = 4; else n_ila = m_ila + 1;
         end
      default: if (!s) begin
           if (frame_tick) begin
             n_low = m_low + 1;
             if (n_low == RF) begin inc_r = 1; n_ph = 0; end
           end
         end else begin
           if (!m_prev_s) inc_e = 1;
           n_low = 0;
         end
    endcase
    if (!lane) begin n_ph = 0; n_first = 0; end
    if (n_ph == 4 && m_ph != 4) n_low = 0;
    @(posedge clk); #1;
    if (!rst_n) begin
      m_ph = 0; m_good = 0; m_ila = 0; m_low = 0; m_err = 0; m_res = 0;
      m_first = 0; m_prev_s = 1;
    end else begin
      m_ph = n_ph; m_good = n_good; m_ila = n_ila; m_low = n_low; m_first = n_first;
      m_prev_s = s;
      if (cnt_clr) begin m_err = 0; m_res = 0; end
      else begin
        if (inc_e && m_err < 255) m_err++;
        if (inc_r && m_res < 255) m_res++;
      end
    end
  endtask

  initial begin
    int e_cnt, ila_at, data_at, ila_en_seen;
    rst_n = 0; lane_en = 4'b0101; subclassv = 3'd1; sync = 2'b00; lmfc_synced = 0;
    lmfc_edge = 0; frame_tick = 0; ila_delay = 8'd2; ila_mf = 8'd0; cnt_clr = 0;
    m_ph = 0; m_good = 0; m_ila = 0; m_low = 0; m_err = 0; m_res = 0; m_first = 0; m_prev_s = 1;
    step(0);
    step(1);
    chk("rst_STATE", 32'(state), 32'h01);
    chk("rst_outputs", {lmfc_en, ila_en, char_en, ila_start, link_up}, 32'd0);
    chk("rst_counters", {err_cnt, res_cnt}, 32'd0);

    // Subclass 1, ILA_DELAY=2, ILA length default 4
    rst_n = 1;
    step(1); step(1);
    lmfc_synced = 1; sync = 2'b11;
    step(1);
    e_cnt = 0; ila_at = -1; data_at = -1; ila_en_seen = 0;
    for (int i = 0; i < 40; i++) begin
      lmfc_edge = (i % 4 == 3);
      if (lmfc_edge) e_cnt++;
      step(1);
      if (ila_start === 1'b1 && ila_at < 0) begin ila_at = e_cnt; ila_en_seen = int'(ila_en); end
      if (link_up === 1'b1 && data_at < 0) data_at = e_cnt;
    end
    lmfc_edge = 0;
    chk("ila_start_edge", 32'(ila_at), 32'd3);
    chk("ila_en_pattern", 32'(ila_en_seen), 32'h5);
    chk("data_edge", 32'(data_at), 32'd7);
    chk("char_en_pattern", 32'(char_en), 32'h5);

    // Short SYNC low (3 ticks): error report, link stays up
    sync = 2'b00;
    for (int k = 0; k < 6; k++) begin frame_tick = (k % 2 == 1); step(1); end
    frame_tick = 0; sync = 2'b11;
    step(1);
    chk("short_low_linkup", 32'(link_up), 32'd1);
    chk("short_low_errcnt", 32'(err_cnt), 32'd1);
    // Long SYNC low (5 ticks): resync
    sync = 2'b00;
    for (int k = 0; k < 10; k++) begin frame_tick = (k % 2 == 1); step(1); end
    frame_tick = 0;
    chk("long_low_linkup", 32'(link_up), 32'd0);
    chk("long_low_rescnt", 32'(res_cnt), 32'd1);

    // Subclass 0, ILA_DELAY=0, one-multiframe ILA
    subclassv = 3'd0; ila_delay = 8'd0; ila_mf = 8'd1; sync = 2'b11; lmfc_edge = 1;
    step(1);
    chk("sc0_no_align", 32'(state), 32'h04);
    step(1);
    chk("sc0_ila_start", 32'(ila_start), 32'd1);
    step(1);
    chk("sc0_data", 32'(link_up), 32'd1);
    // All lanes disabled in DATA
    lane_en = 4'b0000;
    #1;
    chk("lane_off_char_en", 32'(char_en), 32'd0);
    step(1);
    chk("lane_off_idle", 32'(state), 32'h01);
    lane_en = 4'b0101;

    // Repeated ILA aborts via one SYNC input low; counter saturates
    for (int n = 0; n < 256; n++) begin
      sync = 2'b11; step(1); step(1);
      sync = 2'b10; step(1);
    end
    chk("abort_saturate", 32'(res_cnt), 32'd255);
    sync = 2'b11; step(1); step(1);
    sync = 2'b10; cnt_clr = 1; step(1);
    cnt_clr = 0;
    chk("clr_vs_abort_res", 32'(res_cnt), 32'd0);
    chk("clr_vs_abort_err", 32'(err_cnt), 32'd0);

    // Reset mid-ILA
    sync = 2'b11; step(1); step(1);
    sync = 2'b10; step(1);
    sync = 2'b11; step(1); step(1);
    chk("pre_rst_in_ila", 32'(state), 32'h08);
    rst_n = 0; step(1);
    chk("rst_ila_state", 32'(state), 32'h01);
    chk("rst_ila_outputs", {lmfc_en, ila_en, char_en, ila_start, link_up}, 32'd0);
    chk("rst_ila_counters", {err_cnt, res_cnt}, 32'd0);
    rst_n = 1; step(1); step(1);
    chk("restart_ila", 32'(ila_start), 32'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      lane_en     = ($urandom_range(0, 29) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      sync        = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      lmfc_edge   = ($urandom_range(0, 3) == 0);
      frame_tick  = ($urandom_range(0, 2) == 0);
      lmfc_synced = ($urandom_range(0, 3) != 0);
      cnt_clr     = ($urandom_range(0, 99) == 0);
      if (m_ph == 0) begin
        subclassv = 3'($urandom_range(0, 7));
        ila_delay = 8'($urandom_range(0, 3));
        ila_mf    = 8'($urandom_range(0, 3));
      end
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
